// File: rtl/pq_cmd_issuer.sv
// pq_cmd_issuer: issues ENQUEUE / DEQUEUE / REPLACE commands to a priority
// queue through single-cycle strobes. Each strobe is followed by a
// per-operation idle gap, and then a response is held until it is consumed.
// Commands that cannot be serviced are answered with an error and never
// touch the queue.
// Optional: define PQ_CMD_ISSUER_STATS_EN to add saturating issue/reject
// counters (o_issue_cnt, o_reject_cnt).
module pq_cmd_issuer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ENQUEUE_GAP = 4,
  parameter int DEQUEUE_GAP = 24,
  parameter int REPLACE_GAP = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data
`ifdef PQ_CMD_ISSUER_STATS_EN
  ,
  output logic [31:0]           o_issue_cnt,
  output logic [15:0]           o_reject_cnt
`endif
);

  localparam int MAX_GAP_01 = (ENQUEUE_GAP > DEQUEUE_GAP) ? ENQUEUE_GAP : DEQUEUE_GAP;
  localparam int MAX_GAP    = (MAX_GAP_01 > REPLACE_GAP) ? MAX_GAP_01 : REPLACE_GAP;
  localparam int CNT_W      = $clog2(MAX_GAP) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ENQ = 2'd0,
    OP_DEQ = 2'd1,
    OP_REP = 2'd2,
    OP_RSV = 2'd3
  } op_t;

  state_t                  state_q;
  state_t                  state_d;
  op_t                     op_q;
  op_t                     cmd_op;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    err_q;
  logic [CNT_W-1:0]        gap_q;
  logic [CNT_W-1:0]        gap_load;
  logic                    accept;
  logic                    reject;

  assign cmd_op = op_t'(i_cmd_op);
  assign accept = i_cmd_valid && (state_q == S_IDLE);

  // Rejection is judged on the flags seen in the acceptance cycle.
  always_comb begin
    reject = 1'b0;
    case (cmd_op)
      OP_ENQ:  reject = i_pq_full;
      OP_DEQ:  reject = i_pq_empty;
      OP_REP:  reject = i_pq_empty;
      default: reject = 1'b1;
    endcase
  end

  // Gap counter load value for the latched op (counts down to zero).
  always_comb begin
    gap_load = '0;
    case (op_q)
      OP_ENQ:  gap_load = CNT_W'(ENQUEUE_GAP - 1);
      OP_DEQ:  gap_load = CNT_W'(DEQUEUE_GAP - 1);
      OP_REP:  gap_load = CNT_W'(REPLACE_GAP - 1);
      default: gap_load = '0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = reject ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_GAP;
      S_GAP:   if (gap_q == '0) state_d = S_RESP;
      S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, result capture and gap countdown.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_q     <= OP_ENQ;
      data_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      gap_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            data_q   <= i_cmd_data;
            err_q    <= reject;
            result_q <= '0;
          end
        end
        S_ISSUE: begin
          result_q <= (op_q == OP_ENQ) ? '0 : i_pq_data;
          gap_q    <= gap_load;
        end
        S_GAP: begin
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state; strobes exist only in ISSUE.
  always_comb begin
    o_cmd_ready = (state_q == S_IDLE);
    o_rsp_valid = (state_q == S_RESP);
    o_rsp_data  = (state_q == S_RESP) ? result_q : '0;
    o_rsp_err   = (state_q == S_RESP) && err_q;
    o_pq_wrt    = (state_q == S_ISSUE) && ((op_q == OP_ENQ) || (op_q == OP_REP));
    o_pq_read   = (state_q == S_ISSUE) && ((op_q == OP_DEQ) || (op_q == OP_REP));
    o_pq_data   = (state_q == S_ISSUE) ? data_q : '0;
  end

`ifdef PQ_CMD_ISSUER_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [15:0] reject_cnt_q;

  // Saturating activity counters.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      issue_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else begin
      if ((state_q == S_ISSUE) && (issue_cnt_q != '1))
        issue_cnt_q <= issue_cnt_q + 1'b1;
      if (accept && reject && (reject_cnt_q != '1))
        reject_cnt_q <= reject_cnt_q + 1'b1;
    end
  end

  assign o_issue_cnt  = issue_cnt_q;
  assign o_reject_cnt = reject_cnt_q;
`endif

endmodule

// File: tb/tb_pq_cmd_issuer.sv
// Self-checking bench for pq_cmd_issuer: a transaction-level model checked
// every cycle, plus directed commands with hand-computed results.
module tb_pq_cmd_issuer;

  localparam int DW = 16;
  localparam int EG = 4;
  localparam int DG = 24;
  localparam int RG = 4;

  logic          CLK;
  logic          RSTn;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_op;
  logic [DW-1:0] i_cmd_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_pq_wrt;
  logic          o_pq_read;
  logic [DW-1:0] o_pq_data;
  logic          i_pq_full;
  logic          i_pq_empty;
  logic [DW-1:0] i_pq_data;
`ifdef PQ_CMD_ISSUER_STATS_EN
  logic [31:0]   o_issue_cnt;
  logic [15:0]   o_reject_cnt;
`endif

  pq_cmd_issuer #(
    .DATA_WIDTH (DW),
    .ENQUEUE_GAP(EG),
    .DEQUEUE_GAP(DG),
    .REPLACE_GAP(RG)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_op   (i_cmd_op),
    .i_cmd_data (i_cmd_data),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_pq_wrt   (o_pq_wrt),
    .o_pq_read  (o_pq_read),
    .o_pq_data  (o_pq_data),
    .i_pq_full  (i_pq_full),
    .i_pq_empty (i_pq_empty),
    .i_pq_data  (i_pq_data)
`ifdef PQ_CMD_ISSUER_STATS_EN
    ,
    .o_issue_cnt (o_issue_cnt),
    .o_reject_cnt(o_reject_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // d counts edges since the acceptance edge (1 = strobe cycle).
  bit          m_busy = 1'b0;
  int          m_d    = 0;
  int          m_gap  = 0;
  bit          m_rej  = 1'b0;
  logic [1:0]  m_op   = '0;
  logic [DW-1:0] m_data  = '0;
  logic [DW-1:0] m_rdata = '0;
  int          m_issues  = 0;
  int          m_rejects = 0;

  function automatic bit e_issue();
    return m_busy && !m_rej && (m_d == 1);
  endfunction

  function automatic bit e_valid();
    return m_busy && (m_d >= (m_rej ? 1 : 2 + m_gap));
  endfunction

  function automatic int gap_of(input logic [1:0] op);
    return (op == 2'd0) ? EG : (op == 2'd1) ? DG : RG;
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_busy    = 1'b0;
      m_issues  = 0;
      m_rejects = 0;
    end else if (!m_busy) begin
      if (i_cmd_valid) begin
        m_busy  = 1'b1;
        m_d     = 1;
        m_op    = i_cmd_op;
        m_data  = i_cmd_data;
        m_gap   = gap_of(i_cmd_op);
        m_rdata = '0;
        m_rej   = (i_cmd_op == 2'd3) || (i_cmd_op == 2'd0 && i_pq_full) ||
                  (i_cmd_op != 2'd0 && i_pq_empty);
        if (m_rej) m_rejects++;
      end
    end else if (e_valid() && i_rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      if (e_issue()) begin
        m_rdata = (m_op == 2'd0) ? '0 : i_pq_data;
        m_issues++;
      end
      m_d++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    bit iss;
    bit vld;
    iss = e_issue();
    vld = e_valid();
    chk("cmd_ready", {31'd0, o_cmd_ready}, {31'd0, !m_busy});
    chk("pq_wrt",    {31'd0, o_pq_wrt},    {31'd0, iss && (m_op == 2'd0 || m_op == 2'd2)});
    chk("pq_read",   {31'd0, o_pq_read},   {31'd0, iss && (m_op == 2'd1 || m_op == 2'd2)});
    chk("pq_data",   {16'd0, o_pq_data},   {16'd0, iss ? m_data : 16'd0});
    chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, vld});
    chk("rsp_err",   {31'd0, o_rsp_err},   {31'd0, vld && m_rej});
    chk("rsp_data",  {16'd0, o_rsp_data},  {16'd0, (vld && !m_rej) ? m_rdata : 16'd0});
`ifdef PQ_CMD_ISSUER_STATS_EN
    chk("issue_cnt",  o_issue_cnt,          m_issues);
    chk("reject_cnt", {16'd0, o_reject_cnt}, m_rejects);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [DW-1:0] d,
                         input logic full, input logic empty, input logic [DW-1:0] pqd,
                         input int rdy_delay, input bit noisy, input int e_lat,
                         input logic [DW-1:0] e_data, input logic e_err,
                         input int e_wrt, input int e_rd, input logic [DW-1:0] e_pqd);
    int n;
    int wrt_n;
    int rd_n;
    logic [DW-1:0] pqd_seen;
    @(negedge CLK);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = d;
    i_pq_full   = full;
    i_pq_empty  = empty;
    i_pq_data   = pqd;
    i_rsp_ready = 1'b0;
    @(negedge CLK);
    i_cmd_valid = noisy;
    n = 1; wrt_n = 0; rd_n = 0; pqd_seen = '0;
    while (!o_rsp_valid && n < 200) begin
      if (o_pq_wrt) pqd_seen = o_pq_data;
      wrt_n += int'(o_pq_wrt);
      rd_n  += int'(o_pq_read);
      if (noisy) begin
        i_cmd_op   = 2'($urandom);
        i_cmd_data = DW'($urandom);
      end
      @(negedge CLK);
      n++;
    end
    chk({nm, "_latency"}, n, e_lat);
    chk({nm, "_data"}, {16'd0, o_rsp_data}, {16'd0, e_data});
    chk({nm, "_err"}, {31'd0, o_rsp_err}, {31'd0, e_err});
    chk({nm, "_wrt_count"}, wrt_n, e_wrt);
    chk({nm, "_read_count"}, rd_n, e_rd);
    chk({nm, "_pq_data"}, {16'd0, pqd_seen}, {16'd0, e_pqd});
    repeat (rdy_delay) begin
      chk({nm, "_ready_busy"}, {31'd0, o_cmd_ready}, 32'd0);
      @(negedge CLK);
    end
    chk({nm, "_data_held"}, {16'd0, o_rsp_data}, {16'd0, e_data});
    i_rsp_ready = 1'b1;
    if (noisy) i_cmd_op = 2'd3;
    @(negedge CLK);
    chk({nm, "_valid_cleared"}, {31'd0, o_rsp_valid}, 32'd0);
    if (noisy) begin
      // Reserved op left on the bus gets accepted next edge and rejected.
      @(negedge CLK);
      i_cmd_valid = 1'b0;
      repeat (2) @(negedge CLK);
    end else begin
      chk({nm, "_ready_after"}, {31'd0, o_cmd_ready}, 32'd1);
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset_check(input string nm);
    #2 RSTn = 1'b0;
    #1;
    chk({nm, "_wrt"}, {31'd0, o_pq_wrt}, 32'd0);
    chk({nm, "_read"}, {31'd0, o_pq_read}, 32'd0);
    chk({nm, "_pq_data"}, {16'd0, o_pq_data}, 32'd0);
    chk({nm, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    chk({nm, "_rsp_data"}, {16'd0, o_rsp_data}, 32'd0);
    chk({nm, "_rsp_err"}, {31'd0, o_rsp_err}, 32'd0);
    @(negedge CLK);
    #2 RSTn = 1'b1;
  endtask

  initial begin
    RSTn = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_data = '0;
    i_rsp_ready = 1'b0; i_pq_full = 1'b0; i_pq_empty = 1'b1; i_pq_data = '0;
    repeat (3) @(negedge CLK);
    chk("reset_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_rsp_valid}, 32'd0);
    #2 RSTn = 1'b1;

    //       name        op    data      full  empty pq_data  rdly noisy lat  rsp_data  err wrt rd  strobe data
    run_cmd("enq",      2'd0, 16'h0100, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 6,  16'h0000, 1'b0, 1, 0, 16'h0100);
    run_cmd("replace",  2'd2, 16'h0050, 1'b0, 1'b0, 16'h03FF, 2, 1'b0, 6,  16'h03FF, 1'b0, 1, 1, 16'h0050);
    run_cmd("deq_empty",2'd1, 16'h1111, 1'b0, 1'b1, 16'h0AAA, 0, 1'b0, 1,  16'h0000, 1'b1, 0, 0, 16'h0000);
    run_cmd("deq_long", 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0200, 10,1'b0, 26, 16'h0200, 1'b0, 0, 1, 16'h0000);
    run_cmd("enq_full", 2'd0, 16'h7777, 1'b1, 1'b0, 16'h0123, 1, 1'b0, 1,  16'h0000, 1'b1, 0, 0, 16'h0000);
    run_cmd("op3",      2'd3, 16'h5555, 1'b0, 1'b0, 16'h0123, 0, 1'b0, 1,  16'h0000, 1'b1, 0, 0, 16'h0000);
    run_cmd("rep_empty",2'd2, 16'h0042, 1'b0, 1'b1, 16'h0099, 0, 1'b0, 1,  16'h0000, 1'b1, 0, 0, 16'h0000);
    run_cmd("enq_noisy",2'd0, 16'h1234, 1'b0, 1'b0, 16'hBEEF, 3, 1'b1, 6,  16'h0000, 1'b0, 1, 0, 16'h1234);
    run_cmd("rep_max",  2'd2, 16'hFFFF, 1'b1, 1'b0, 16'hFFFE, 0, 1'b0, 6,  16'hFFFE, 1'b0, 1, 1, 16'hFFFF);

    // Reset asserted while the strobe is high.
    @(negedge CLK);
    i_cmd_valid = 1'b1; i_cmd_op = 2'd2; i_cmd_data = 16'h0ABC;
    i_pq_full = 1'b0; i_pq_empty = 1'b0; i_pq_data = 16'h0F00;
    @(negedge CLK);
    i_cmd_valid = 1'b0;
    chk("issue_wrt_before_rst", {31'd0, o_pq_wrt}, 32'd1);
    pulse_reset_check("rst_issue");

    // Reset asserted during the dequeue gap.
    @(negedge CLK);
    i_cmd_valid = 1'b1; i_cmd_op = 2'd1; i_pq_data = 16'h0321;
    @(negedge CLK);
    i_cmd_valid = 1'b0;
    repeat (6) @(negedge CLK);
    pulse_reset_check("rst_gap");

    // First command after release runs normally.
    run_cmd("enq_after_rst", 2'd0, 16'h00C3, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 6, 16'h0000, 1'b0, 1, 0, 16'h00C3);
    run_cmd("deq_after_rst", 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0321, 0, 1'b0, 26, 16'h0321, 1'b0, 0, 1, 16'h0000);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
